spi_reg_writer: RTL and testbench



---
 rtl/spi_reg_writer.sv | 143 ++++++++++++++
 tb/tb_spi_reg_writer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_writer.sv
// SPI controller for the 16-bit register-write link: one {1, addr[6:0], data[7:0]}
// frame per accepted command, MSB first, with copi updated mid-way through each low phase.
module spi_reg_writer #(
    parameter int CLK_DIV = 50,
    parameter int CS_GAP  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       ncs,
    output logic       sclk,
    output logic       copi,
    output logic [2:0] dbg_state
);

    // Handshake: a command transfers on the clk edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on state, and cmd_valid has no effect outside IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_MID  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] GAP_DONE = CW'(CS_GAP - 2);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [14:0]   r_shift;
    logic          r_ncs;
    logic          r_sclk;
    logic          r_copi;
    logic          r_done;

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign ncs       = r_ncs;
    assign sclk      = r_sclk;
    assign copi      = r_copi;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 4'd0;
            r_shift <= '0;
            r_ncs   <= 1'b1;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // Bit 15 (write flag) goes straight onto copi; the shift
                        // register only needs to hold the remaining 15 bits.
                        r_shift <= {cmd_addr, cmd_data};
                        r_copi  <= 1'b1;
                        r_ncs   <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= 4'd15;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (r_sclk) begin
                        if (r_cnt == DIV_LAST) begin
                            r_cnt  <= '0;
                            r_sclk <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end else begin
                        // Next bit is presented mid low phase so it is far from both
                        // sampling edges; nothing follows the final bit.
                        if (r_cnt == DIV_MID && r_bit != 4'd0) begin
                            r_copi  <= r_shift[14];
                            r_shift <= {r_shift[13:0], 1'b0};
                        end
                        if (r_cnt == DIV_LAST) begin
                            r_cnt <= '0;
                            if (r_bit == 4'd0) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit  <= r_bit - 4'd1;
                                r_sclk <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == DIV_LAST) begin
                        r_cnt   <= '0;
                        r_ncs   <= 1'b1;
                        r_copi  <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        // Registered one cycle early so done coincides with the last GAP cycle.
                        if (r_cnt == GAP_DONE) r_done <= 1'b1;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer with a falling-edge-sampling register-map peripheral model.
module tb_spi_reg_writer;

    localparam int CLK_DIV     = 50;
    localparam int CS_GAP      = 20;
    localparam int NCS_LOW_EXP = 1700;  // 34 * 50
    localparam int LAT_EXP     = 1721;  // 1 + 34 * 50 + 20
    localparam int GAP_EXP     = 21;    // CS_GAP + 1
    localparam int WAIT_MAX    = 4000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = 7'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, busy, done, ncs, sclk, copi;
    logic [2:0] dbg_state;

    int checks = 0;
    int failures = 0;

    spi_reg_writer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done),
        .ncs(ncs), .sclk(sclk), .copi(copi), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Peripheral model and line monitors
    logic [15:0] p_shift = 16'd0;
    int          p_fall = 0, p_rise = 0;
    logic [15:0] reg_en_out = 16'd0, reg_en_pwm = 16'd0;
    logic [7:0]  reg_pwm_duty = 8'd0;
    logic [15:0] last_frame = 16'd0;
    int          last_fall = 0, last_rise = 0, last_low = 0;
    int          frames_started = 0, low_run = 0, high_run = 0, min_high = 1000000;
    int          done_cnt = 0, copi_viol = 0;
    time         t_sclk = 0, t_copi = 0;

    always @(negedge ncs) begin
        p_fall = 0; p_rise = 0; p_shift = 16'd0; low_run = 0;
        frames_started++;
        if (high_run < min_high) min_high = high_run;
    end

    always @(posedge ncs) begin
        last_frame = p_shift; last_fall = p_fall; last_rise = p_rise; last_low = low_run;
        high_run = 0;
        if (p_fall == 16 && p_shift[15]) begin
            case (p_shift[14:8])
                7'h00: reg_en_out[7:0]  = p_shift[7:0];
                7'h01: reg_en_out[15:8] = p_shift[7:0];
                7'h02: reg_en_pwm[7:0]  = p_shift[7:0];
                7'h03: reg_en_pwm[15:8] = p_shift[7:0];
                7'h04: reg_pwm_duty     = p_shift[7:0];
                default: ;
            endcase
        end
    end

    always @(negedge sclk) if (ncs === 1'b0) begin
        p_shift = {p_shift[14:0], copi};
        p_fall++;
    end
    always @(posedge sclk) if (ncs === 1'b0) p_rise++;

    always @(sclk) begin
        t_sclk = $time;
        if (rst_n === 1'b1 && $time > 100 && t_copi == $time) copi_viol++;
    end
    always @(copi) begin
        t_copi = $time;
        if (rst_n === 1'b1 && $time > 100 && (sclk === 1'b1 || t_sclk == $time)) copi_viol++;
    end

    always @(negedge clk) begin
        if (ncs === 1'b0) low_run++;
        else if (ncs === 1'b1) high_run++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic wait_ready();
        int w = 0;
        while (cmd_ready !== 1'b1 && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= WAIT_MAX) begin
            failures++;
            $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, w);
        end
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        wait_ready();
        cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr = 7'($urandom_range(0, 127));
        cmd_data = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < WAIT_MAX);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (ncs !== 1'b1 || sclk !== 1'b0 || copi !== 1'b0 || cmd_ready !== 1'b1 ||
                busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_idle: %0d bad cycles (ncs=%b sclk=%b copi=%b rdy=%b busy=%b done=%b), required 0",
                     bad, ncs, sclk, copi, cmd_ready, busy, done);
        end
        checks++;
        if (dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d, required 0", dbg_state);
        end
        checks++;
        if (done_cnt !== 0) begin
            failures++;
            $display("FAIL reset_done: got %0d pulses, required 0", done_cnt);
        end
    endtask

    task automatic test_single_frame();
        int n;
        send_cmd(7'h00, 8'hA5);
        wait_done(n);
        checks++;
        if (n + 1 !== LAT_EXP) begin
            failures++;
            $display("FAIL latency: got %0d cycles, required %0d", n + 1, LAT_EXP);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_width: done=%b one cycle later, required 0", done);
        end
        checks++;
        if (last_frame !== 16'h80A5) begin
            failures++;
            $display("FAIL frame_a5: got %h, required 80a5", last_frame);
        end
        checks++;
        if (last_rise !== 16 || last_fall !== 16) begin
            failures++;
            $display("FAIL sclk_edges: got rise=%0d fall=%0d, required 16/16", last_rise, last_fall);
        end
        checks++;
        if (last_low !== NCS_LOW_EXP) begin
            failures++;
            $display("FAIL ncs_low: got %0d cycles, required %0d", last_low, NCS_LOW_EXP);
        end
        checks++;
        if (copi_viol !== 0) begin
            failures++;
            $display("FAIL copi_timing: got %0d changes at/around sclk high, required 0", copi_viol);
        end
    endtask

    task automatic test_reg_map();
        int n;
        send_cmd(7'h04, 8'h80);
        wait_done(n);
        checks++;
        if (reg_pwm_duty !== 8'h80 || last_frame !== 16'h8480) begin
            failures++;
            $display("FAIL pwm_duty: got %h frame %h, required 80 frame 8480", reg_pwm_duty, last_frame);
        end
        send_cmd(7'h01, 8'hFF);
        wait_done(n);
        checks++;
        if (reg_en_out !== 16'hFFA5) begin
            failures++;
            $display("FAIL en_out_hi: got %h, required ffa5", reg_en_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] a [3];
        logic [7:0] d [3];
        int n, d0, f0;
        a[0] = 7'h02; d[0] = 8'h0F;
        a[1] = 7'h03; d[1] = 8'hF0;
        a[2] = 7'h00; d[2] = 8'h01;
        @(negedge clk);
        d0 = done_cnt; f0 = frames_started; min_high = 1000000;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_addr = a[i]; cmd_data = d[i];
            wait_ready();
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_done(n);
        @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 3 || frames_started - f0 !== 3) begin
            failures++;
            $display("FAIL b2b_count: got done=%0d frames=%0d, required 3/3", done_cnt - d0, frames_started - f0);
        end
        checks++;
        if (reg_en_pwm !== 16'hF00F) begin
            failures++;
            $display("FAIL b2b_en_pwm: got %h, required f00f", reg_en_pwm);
        end
        checks++;
        if (reg_en_out !== 16'hFF01) begin
            failures++;
            $display("FAIL b2b_en_out: got %h, required ff01", reg_en_out);
        end
        checks++;
        if (min_high !== GAP_EXP) begin
            failures++;
            $display("FAIL b2b_gap: got %0d ncs-high cycles, required %0d", min_high, GAP_EXP);
        end
    endtask

    task automatic test_mid_frame_ignore();
        int n, f0;
        f0 = frames_started;
        send_cmd(7'h02, 8'h33);
        repeat (500) @(negedge clk);
        cmd_addr = 7'h7E; cmd_data = 8'hC3; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_ready: got ready=%b busy=%b, required 0/1", cmd_ready, busy);
        end
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(n);
        repeat (50) @(negedge clk);
        checks++;
        if (frames_started - f0 !== 1 || last_frame !== 16'h8233) begin
            failures++;
            $display("FAIL mid_frame: got frames=%0d frame=%h, required 1 frame 8233", frames_started - f0, last_frame);
        end
        checks++;
        if (reg_en_pwm !== 16'hF033) begin
            failures++;
            $display("FAIL mid_en_pwm: got %h, required f033", reg_en_pwm);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n, w = 0, d0;
        send_cmd(7'h00, 8'h3C);
        while (!(p_fall == 8 && sclk === 1'b1) && w < WAIT_MAX) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= WAIT_MAX) begin
            failures++;
            $display("FAIL bit7_wait: fall=%0d sclk=%b, required 8/1", p_fall, sclk);
        end
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ncs !== 1'b1 || sclk !== 1'b0 || copi !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got ncs=%b sclk=%b copi=%b busy=%b done=%b, required 1/0/0/0/0",
                     ncs, sclk, copi, busy, done);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || reg_en_out !== 16'hFF01) begin
            failures++;
            $display("FAIL abort_silent: got done=%0d en_out=%h, required %0d/ff01", done_cnt - d0, reg_en_out, 0);
        end
        send_cmd(7'h00, 8'h3C);
        wait_done(n);
        checks++;
        if (last_frame !== 16'h803C || reg_en_out !== 16'hFF3C) begin
            failures++;
            $display("FAIL post_reset_frame: got %h en_out=%h, required 803c/ff3c", last_frame, reg_en_out);
        end
        checks++;
        if (n + 1 !== LAT_EXP) begin
            failures++;
            $display("FAIL post_reset_latency: got %0d, required %0d", n + 1, LAT_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_reg_map();
        test_back_to_back();
        test_mid_frame_ignore();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
